jk_bank_sched: RTL and testbench
================================

# jk_bank_sched

Scheduler that shares one bank of JK edge flip-flops (the jkEdgeFF bank) between several requesters. It round-robin arbitrates requests, then either sequences a synchronous J/K update with a generated clock strobe, or drives timed asynchronous preset/clear pulses. It sits between requesting test/control agents and the flip-flop bank. It returns a completion pulse carrying a snapshot of the bank outputs.

## Interface
- NUM_FF, 14: flip-flops in the bank.
- NUM_REQ, 4: requesters (≥2).
- PULSE_CYC, 2: cycles preset/clear stays low (≥1).
- RECOV_CYC, 1: recovery cycles after an async pulse before done (≥1).

Ports:
- clock  in  1  single clock; all state on rising edge.
- clear  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_op  in  NUM_REQ×3  op per requester.
- req_mask  in  NUM_REQ×NUM_FF  target flip-flops per requester.
- req_ready  out  NUM_REQ  one-hot grant pulse; transfer when valid&ready.
- ff_j, ff_k  out  NUM_FF  J/K inputs to the bank.
- ff_clk  out  1  bank clock strobe.
- ff_preset_n, ff_clear_n  out  NUM_FF  async controls to the bank, active-low.
- ff_q  in  NUM_FF  bank outputs.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  clog2(NUM_REQ)  requester of the completed op.
- done_err  out  1  completed op was illegal.
- q_snap  out  NUM_FF  ff_q captured at op end.

## Operation
- Ops:
  - 0 NOP.
  - 1 SET: j=1, k=0.
  - 2 RESET: j=0, k=1.
  - 3 TOGGLE: j=1, k=1.
  - 4 APRESET.
  - 5 ACLEAR.
  - 6–7 illegal: executed as NOP with done_err=1.
- Masked-out bits always see j=k=0 and preset_n=clear_n=1.
- An all-zero mask still runs the full sequence, with no effect on the bank.
- Arbitration happens in IDLE only. The round-robin pointer starts at 0. After a grant to i, requester i+1 (mod NUM_REQ) has highest priority. Op and mask are latched at grant.
- Requesters hold valid/op/mask stable until ready. Dropping valid before ready is permitted and loses nothing.
- FSM states: IDLE, SETUP, STROBE, HOLD, PULSE, RECOVER.
- Transitions:
  - IDLE → SETUP on a grant of ops 0–3 or 6–7.
  - IDLE → PULSE on a grant of ops 4–5.
  - SETUP → STROBE → HOLD → IDLE, one cycle each.
  - PULSE lasts PULSE_CYC cycles, then RECOVER lasts RECOV_CYC cycles, then IDLE.
- Sync sequence:
  - ff_j/ff_k are driven through SETUP, STROBE and HOLD.
  - ff_clk=1 only in STROBE.
  - On exit of HOLD, ff_q is captured into q_snap.
- Async sequence:
  - ff_preset_n or ff_clear_n is low on masked bits throughout PULSE.
  - All are high in RECOVER.
  - ff_q is captured on exit of RECOVER.
- Never at the same time: preset_n low and clear_n low, or ff_clk high and any async control low.

## Timing
- Reset values (while clear=0, immediately and asynchronously):
  - state IDLE, pointer 0.
  - req_ready=0, ff_j=ff_k=0, ff_clk=0.
  - ff_preset_n=ff_clear_n all-ones.
  - busy=0, done=0, done_id=0, done_err=0, q_snap=0.
- Reset mid-operation aborts the op, drives all outputs to those values and loses the in-flight request. No done is produced.
- Grant is cycle 0: req_ready is high combinationally in IDLE, and at most one bit is set.
- Sync op:
  - ff_j/ff_k valid in cycles 1–3.
  - ff_clk high in cycle 2.
  - done, done_id, done_err and q_snap valid in cycle 4.
- Async op:
  - pulse low in cycles 1..PULSE_CYC.
  - done in cycle 1+PULSE_CYC+RECOV_CYC (cycle 4 with defaults).
- The done cycle is IDLE, so a new grant may occur in that same cycle. Back-to-back sync ops therefore issue every 4 cycles.
- q_snap holds its value until the next done.

## Structure
- Package jk_ctrl_pkg holds:
  - op_e with the 3-bit op encodings;
  - state_e for the FSM states;
  - the J/K decode function from op to {j,k}.
- Sub-module rr_arbiter (parameter N) provides a valid vector in, a one-hot grant and index out, and a pointer update on accept.
- FSM, pulse counter and datapath live in jk_bank_sched.

## Test plan
- Reset then idle: all outputs at their reset values; busy=0; no ready pulses.
- Req0 SET with mask 0x0003, ff_q wired from a bank model: ready[0] at c0; ff_j=0x0003, ff_k=0 during c1–c3; ff_clk high only at c2; done at c4 with done_id=0 and q_snap bits[1:0]=11.
- All four requesters hold valid with TOGGLE: grant order 0,1,2,3,0 at 4-cycle spacing; q_snap toggles each time.
- Req2 ACLEAR mask 0x3FFF: ff_clear_n=0 for exactly cycles 1–2, ff_preset_n stays high, ff_clk never high; done at c4 with q_snap=0.
- Req1 op 7: full sync sequence with ff_j=ff_k=0; done at c4 with done_err=1.
- clear asserted during PULSE: ff_clear_n returns high immediately; no done; after release, the next request is granted starting from pointer 0.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared op/state encodings and J/K decode for the JK flip-flop bank scheduler.
package jk_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_SET     = 3'd1,
        OP_RESET   = 3'd2,
        OP_TOGGLE  = 3'd3,
        OP_APRESET = 3'd4,
        OP_ACLEAR  = 3'd5,
        OP_ILL6    = 3'd6,
        OP_ILL7    = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_HOLD    = 3'd3,
        S_PULSE   = 3'd4,
        S_RECOVER = 3'd5
    } state_e;

    // Returns {j,k}; illegal and async ops leave the synchronous inputs idle.
    function automatic logic [1:0] jk_decode(input op_e op);
        case (op)
            OP_SET:    return 2'b10;
            OP_RESET:  return 2'b01;
            OP_TOGGLE: return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic op_is_async(input op_e op);
        return (op == OP_APRESET) || (op == OP_ACLEAR);
    endfunction

    function automatic logic op_is_illegal(input op_e op);
        return (op == OP_ILL6) || (op == OP_ILL7);
    endfunction

endpackage

// File: rtl/jk_bank_sched_if.sv
// Requester bus and flip-flop bank connections for jk_bank_sched.
interface jk_bank_sched_if #(
    parameter int NUM_FF  = 14,
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*3-1:0]      req_op;
    logic [NUM_REQ*NUM_FF-1:0] req_mask;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_FF-1:0]         ff_j;
    logic [NUM_FF-1:0]         ff_k;
    logic                      ff_clk;
    logic [NUM_FF-1:0]         ff_preset_n;
    logic [NUM_FF-1:0]         ff_clear_n;
    logic [NUM_FF-1:0]         ff_q;
    logic                      busy;
    logic                      done;
    logic [IDW-1:0]            done_id;
    logic                      done_err;
    logic [NUM_FF-1:0]         q_snap;

    modport slave (
        input  req_valid, req_op, req_mask, ff_q,
        output req_ready, ff_j, ff_k, ff_clk, ff_preset_n, ff_clear_n,
               busy, done, done_id, done_err, q_snap
    );

    modport master (
        output req_valid, req_op, req_mask, ff_q,
        input  req_ready, ff_j, ff_k, ff_clk, ff_preset_n, ff_clear_n,
               busy, done, done_id, done_err, q_snap
    );
endinterface

// File: rtl/jk_bank_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a valid vector, pointer moves past the winner.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clock,
    input  logic          clear,
    input  logic [N-1:0]  i_valid,
    input  logic          i_en,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [IW-1:0] r_ptr;
    int            w_k;

    // Scan starting at the pointer; the first valid requester found wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_k     = 0;
        for (int i = 0; i < N; i++) begin
            w_k = int'(r_ptr) + i;
            if (w_k >= N) w_k = w_k - N;
            if (!o_any && i_en && i_valid[w_k[IW-1:0]]) begin
                o_any              = 1'b1;
                o_grant[w_k[IW-1:0]] = 1'b1;
                o_idx              = w_k[IW-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_ptr <= '0;
        end else if (o_any) begin
            r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
        end
    end
endmodule

// File: rtl/jk_bank_sched.sv
// Shares one JK flip-flop bank between requesters: arbitrate, then run a
// synchronous J/K strobe or a timed asynchronous preset/clear pulse.
//
//   state     | meaning
//   IDLE      | arbitrate; done pulse of the previous op shows here
//   SETUP     | J/K driven, bank clock low
//   STROBE    | J/K driven, bank clock high
//   HOLD      | J/K driven, bank clock low; q captured on exit
//   PULSE     | preset_n or clear_n low on masked bits for PULSE_CYC cycles
//   RECOVER   | all async controls high for RECOV_CYC cycles; q captured on exit
module jk_bank_sched
    import jk_ctrl_pkg::*;
#(
    parameter int NUM_FF    = 14,
    parameter int NUM_REQ   = 4,
    parameter int PULSE_CYC = 2,
    parameter int RECOV_CYC = 1
) (
    input logic           clock,
    input logic           clear,
    jk_bank_sched_if.slave bus
);
    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CMAX = (PULSE_CYC > RECOV_CYC) ? PULSE_CYC : RECOV_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] ST_IDLE    = 3'(S_IDLE);
    localparam logic [2:0] ST_SETUP   = 3'(S_SETUP);
    localparam logic [2:0] ST_STROBE  = 3'(S_STROBE);
    localparam logic [2:0] ST_HOLD    = 3'(S_HOLD);
    localparam logic [2:0] ST_PULSE   = 3'(S_PULSE);
    localparam logic [2:0] ST_RECOVER = 3'(S_RECOVER);

    logic [2:0]        r_state;
    op_e               r_op;
    logic [NUM_FF-1:0] r_mask;
    logic [IDW-1:0]    r_id;
    logic [CW-1:0]     r_cnt;
    logic              r_done;
    logic [IDW-1:0]    r_done_id;
    logic              r_done_err;
    logic [NUM_FF-1:0] r_q_snap;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_idx;
    logic               w_any;
    logic               w_arb_en;
    op_e                w_sel_op;
    logic [NUM_FF-1:0]  w_sel_mask;
    logic [1:0]         w_jk;
    logic               w_sync;
    logic               w_finish;

    // Gating with clear keeps req_ready low while reset is held.
    assign w_arb_en = (r_state == ST_IDLE) && clear;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clock   (clock),
        .clear   (clear),
        .i_valid (bus.req_valid),
        .i_en    (w_arb_en),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_op   = op_e'(bus.req_op[int'(w_idx)*3 +: 3]);
    assign w_sel_mask = bus.req_mask[int'(w_idx)*NUM_FF +: NUM_FF];
    assign w_jk       = jk_decode(r_op);
    assign w_sync     = (r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_HOLD);
    assign w_finish   = (r_state == ST_HOLD) || ((r_state == ST_RECOVER) && (r_cnt == '0));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_mask  <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_op   <= w_sel_op;
                        r_mask <= w_sel_mask;
                        r_id   <= w_idx;
                        if (op_is_async(w_sel_op)) begin
                            r_state <= ST_PULSE;
                            r_cnt   <= CW'(PULSE_CYC - 1);
                        end else begin
                            r_state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP:  r_state <= ST_STROBE;
                ST_STROBE: r_state <= ST_HOLD;
                ST_HOLD:   r_state <= ST_IDLE;
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RECOVER;
                        r_cnt   <= CW'(RECOV_CYC - 1);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (r_cnt == '0) r_state <= ST_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_done     <= 1'b0;
            r_done_id  <= '0;
            r_done_err <= 1'b0;
            r_q_snap   <= '0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_done_id  <= r_id;
                r_done_err <= op_is_illegal(r_op);
                r_q_snap   <= bus.ff_q;
            end
        end
    end

    assign bus.req_ready   = w_grant;
    assign bus.ff_j        = w_sync ? (r_mask & {NUM_FF{w_jk[1]}}) : '0;
    assign bus.ff_k        = w_sync ? (r_mask & {NUM_FF{w_jk[0]}}) : '0;
    assign bus.ff_clk      = (r_state == ST_STROBE);
    assign bus.ff_preset_n = ((r_state == ST_PULSE) && (r_op == OP_APRESET)) ? ~r_mask : '1;
    assign bus.ff_clear_n  = ((r_state == ST_PULSE) && (r_op == OP_ACLEAR))  ? ~r_mask : '1;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = r_done;
    assign bus.done_id     = r_done_id;
    assign bus.done_err    = r_done_err;
    assign bus.q_snap      = r_q_snap;
endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: directed steps plus random requests checked
// against an op-level model of the bank and the round-robin rule.
module tb_jk_bank_sched;
    import jk_ctrl_pkg::*;

    localparam int NF = 14;
    localparam int NR = 4;
    localparam int PC = 2;
    localparam int RC = 1;

    logic clock = 1'b0;
    logic clear = 1'b0;
    always #5 clock = ~clock;

    jk_bank_sched_if #(.NUM_FF(NF), .NUM_REQ(NR)) bus ();

    jk_bank_sched #(.NUM_FF(NF), .NUM_REQ(NR), .PULSE_CYC(PC), .RECOV_CYC(RC)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    // Bank model: the strobe and async pulses each last a full cycle, so
    // evaluating them at the falling edge stands in for the real edges.
    logic [NF-1:0] bank_q = '0;
    logic [NF-1:0] bank_nx;
    assign bus.ff_q = bank_q;
    always @(negedge clock) begin
        bank_nx = bank_q;
        for (int i = 0; i < NF; i++) begin
            if (bus.ff_clk) begin
                case ({bus.ff_j[i], bus.ff_k[i]})
                    2'b10:   bank_nx[i] = 1'b1;
                    2'b01:   bank_nx[i] = 1'b0;
                    2'b11:   bank_nx[i] = ~bank_q[i];
                    default: bank_nx[i] = bank_q[i];
                endcase
            end
            if (!bus.ff_preset_n[i]) bank_nx[i] = 1'b1;
            if (!bus.ff_clear_n[i])  bank_nx[i] = 1'b0;
        end
        bank_q <= bank_nx;
    end

    int            n_pass  = 0;
    int            n_total = 0;
    int            ref_ptr = 0;
    logic [NF-1:0] ref_q   = '0;
    logic [NR-1:0] valid   = '0;
    logic [2:0]    ops   [NR];
    logic [NF-1:0] masks [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive();
        bus.req_valid = valid;
        for (int i = 0; i < NR; i++) begin
            bus.req_op[i*3 +: 3]    = ops[i];
            bus.req_mask[i*NF +: NF] = masks[i];
        end
    endtask

    function automatic int pick();
        for (int i = 0; i < NR; i++) begin
            if (valid[(ref_ptr + i) % NR]) return (ref_ptr + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NF-1:0] apply_op(input logic [2:0] op, input logic [NF-1:0] m,
                                                input logic [NF-1:0] q);
        case (op)
            3'd1, 3'd4: return q | m;
            3'd2, 3'd5: return q & ~m;
            3'd3:       return q ^ m;
            default:    return q;
        endcase
    endfunction

    // Entered at cycle 0 (inputs settled); returns in the done cycle, inputs settled.
    task automatic txn(input int g, input bit hold);
        logic [2:0]    op    = ops[g];
        logic [NF-1:0] m     = masks[g];
        bit            async = (op == 3'd4) || (op == 3'd5);
        int            len   = async ? (1 + PC + RC) : 4;
        bit            ej    = !async && (op == 3'd1 || op == 3'd3);
        bit            ek    = !async && (op == 3'd2 || op == 3'd3);
        logic [NR-1:0] eg    = '0;
        logic [NF-1:0] e_j, e_k, e_pre, e_clr;
        eg[g] = 1'b1;
        chk("grant", bus.req_ready, eg);
        ref_ptr = (g + 1) % NR;
        for (int c = 1; c < len; c++) begin
            @(negedge clock); #1;
            e_j   = ej ? m : '0;
            e_k   = ek ? m : '0;
            e_pre = (op == 3'd4 && c <= PC) ? ~m : '1;
            e_clr = (op == 3'd5 && c <= PC) ? ~m : '1;
            chk("busy",      bus.busy, 1);
            chk("no_done",   bus.done, 0);
            chk("no_ready",  bus.req_ready, 0);
            chk("ff_j",      bus.ff_j, e_j);
            chk("ff_k",      bus.ff_k, e_k);
            chk("ff_clk",    bus.ff_clk, (!async && c == 2) ? 1 : 0);
            chk("preset_n",  bus.ff_preset_n, e_pre);
            chk("clear_n",   bus.ff_clear_n, e_clr);
        end
        @(negedge clock);
        if (!hold) valid[g] = 1'b0;
        drive();
        #1;
        ref_q = apply_op(op, m, ref_q);
        chk("done",     bus.done, 1);
        chk("done_id",  bus.done_id, g);
        chk("done_err", bus.done_err, (op >= 3'd6) ? 1 : 0);
        chk("q_snap",   bus.q_snap, ref_q);
        chk("idle",     bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        for (int i = 0; i < NR; i++) begin
            ops[i]   = 3'd3;
            masks[i] = '1;
        end
        // reset with every requester asking: nothing may be granted
        valid = '1;
        drive();
        #12;
        chk("rst_ready",   bus.req_ready, 0);
        chk("rst_busy",    bus.busy, 0);
        chk("rst_done",    bus.done, 0);
        chk("rst_id",      bus.done_id, 0);
        chk("rst_err",     bus.done_err, 0);
        chk("rst_qsnap",   bus.q_snap, 0);
        chk("rst_j",       bus.ff_j, 0);
        chk("rst_k",       bus.ff_k, 0);
        chk("rst_clk",     bus.ff_clk, 0);
        chk("rst_pre",     bus.ff_preset_n, 14'h3FFF);
        chk("rst_clr",     bus.ff_clear_n, 14'h3FFF);
        valid = '0;
        drive();
        @(negedge clock);
        clear = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock); #1;
            chk("idle_ready", bus.req_ready, 0);
            chk("idle_busy",  bus.busy, 0);
            chk("idle_done",  bus.done, 0);
        end

        // req0 SET on the two low bits
        ops[0] = 3'd1; masks[0] = 14'h0003; valid[0] = 1'b1;
        drive(); #1;
        txn(pick(), 1'b0);
        chk("set_qsnap_lo", {30'd0, bus.q_snap[1:0]}, 32'd3);

        // all four hold valid with TOGGLE: four-cycle spacing, rotating grants
        for (int i = 0; i < NR; i++) begin
            ops[i]   = 3'd3;
            masks[i] = NF'($urandom);
        end
        valid = '1;
        drive(); #1;
        for (int t = 0; t < 5; t++) begin
            g = pick();
            txn(g, 1'b1);
        end
        valid = '0;
        drive(); #1;

        // req2 ACLEAR over the whole bank
        @(negedge clock);
        ops[2] = 3'd5; masks[2] = 14'h3FFF; valid[2] = 1'b1;
        drive(); #1;
        txn(pick(), 1'b0);
        chk("aclr_qsnap", bus.q_snap, 0);

        // req1 illegal op 7
        ops[1] = 3'd7; masks[1] = NF'($urandom); valid[1] = 1'b1;
        drive(); #1;
        txn(pick(), 1'b0);

        // random traffic
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NR; i++) begin
                if (!valid[i] && $urandom_range(0, 2) == 0) begin
                    valid[i] = 1'b1;
                    ops[i]   = 3'($urandom_range(0, 7));
                    masks[i] = NF'($urandom);
                end
            end
            drive(); #1;
            g = pick();
            if (g < 0) begin
                chk("rnd_idle_ready", bus.req_ready, 0);
                @(negedge clock);
            end else begin
                txn(g, 1'b0);
            end
        end
        while (valid != '0) begin
            txn(pick(), 1'b0);
        end

        // reset in the middle of an ACLEAR pulse
        @(negedge clock);
        ops[2] = 3'd5; masks[2] = 14'h3FFF; valid = 4'b0100;
        drive(); #1;
        chk("abort_grant", bus.req_ready, 4'b0100);
        @(posedge clock); #2;
        chk("abort_pulse", bus.ff_clear_n, 0);
        clear = 1'b0;
        valid = '0;
        drive(); #1;
        chk("abort_clr_n", bus.ff_clear_n, 14'h3FFF);
        chk("abort_pre_n", bus.ff_preset_n, 14'h3FFF);
        chk("abort_busy",  bus.busy, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock); #1;
            chk("abort_nodone", bus.done, 0);
        end
        clear   = 1'b1;
        ref_ptr = 0;
        @(negedge clock); #1;
        chk("post_nodone", bus.done, 0);
        ops[1] = 3'd1; masks[1] = NF'($urandom);
        ops[3] = 3'd3; masks[3] = NF'($urandom);
        valid  = 4'b1010;
        drive(); #1;
        chk("post_ptr0_grant", bus.req_ready, 4'b0010);
        txn(pick(), 1'b0);
        txn(pick(), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
